pc_sequencer: RTL

Program-counter and run-control stage directly upstream of the I-format CPU core. Holds the architectural PC, drives it to the core's instruction-address input, and captures the core's computed next address on each retired instruction. Provides start, stop and single-step control, retired-instruction counting, and automatic halt on a self-loop, a misaligned target or an instruction budget limit.

---
 rtl/pc_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter and run-control stage feeding the CPU core.
// Holds the architectural PC and retires the core's computed next address
// while running or single-stepping. It halts automatically on a self-loop,
// a misaligned target, or when the instruction budget is reached.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   Start        level; in IDLE, enter RUN (has priority over Step)
//   Stop         level; in RUN, return to IDLE
//   Step         level; in IDLE, retire one instruction per sampled cycle
//   Next_Addr    next PC computed by the core for the current PC_Addr
//   PC_Addr      current PC (registered)
//   Running      high in RUN
//   Halted       high in HALT
//   Halt_Cause   0 none, 1 self-loop, 2 misaligned, 3 budget
//   Step_Done    one-cycle pulse after a step retires
//   Instr_Count  retired-instruction count; wraps modulo 2^32
//   dbg_state    current FSM state (0 IDLE, 1 RUN, 2 HALT)
//
// Control handshake: there is no valid/ready pair here. Start, Stop and
// Step are level inputs sampled on every rising edge. Next_Addr must be
// stable before each edge, and it is consumed only on a retiring edge.
module pc_sequencer #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] MAX_INSTR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Step,
  input  logic [31:0] Next_Addr,
  output logic [31:0] PC_Addr,
  output logic        Running,
  output logic        Halted,
  output logic [1:0]  Halt_Cause,
  output logic        Step_Done,
  output logic [31:0] Instr_Count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_n;
  logic        try_retire;
  logic        retire;
  logic [1:0]  cause_n;
  logic        step_done_n;
  logic [31:0] count_inc;

  assign count_inc = Instr_Count + 32'd1;
  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    cause_n     = Halt_Cause;
    retire      = 1'b0;
    step_done_n = 1'b0;
    try_retire  = 1'b0;

    case (state)
      IDLE: begin
        if (Start) state_n = RUN;
        else if (Step) try_retire = 1'b1;
      end
      RUN: begin
        if (Stop) state_n = IDLE;
        else try_retire = 1'b1;
      end
      default: ;
    endcase

    // A misaligned target blocks the retire. The other halt causes
    // retire first and then halt.
    if (try_retire) begin
      if (Next_Addr[1:0] != 2'b00) begin
        state_n = HALT;
        cause_n = 2'd2;
      end else begin
        retire      = 1'b1;
        step_done_n = (state == IDLE);
        if (Next_Addr == PC_Addr) begin
          state_n = HALT;
          cause_n = 2'd1;
        end else if ((MAX_INSTR != 32'd0) && (count_inc == MAX_INSTR)) begin
          state_n = HALT;
          cause_n = 2'd3;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      PC_Addr     <= BOOT_ADDR;
      Instr_Count <= 32'd0;
      Running     <= 1'b0;
      Halted      <= 1'b0;
      Halt_Cause  <= 2'd0;
      Step_Done   <= 1'b0;
    end else begin
      state      <= state_n;
      Running    <= (state_n == RUN);
      Halted     <= (state_n == HALT);
      Halt_Cause <= cause_n;
      Step_Done  <= step_done_n;
      if (retire) begin
        PC_Addr     <= Next_Addr;
        Instr_Count <= count_inc;
      end
    end
  end

endmodule
